// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared state encodings and default addresses for the pipeline controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Controller states: RUN fetches sequentially, FLUSH is the single
    // bubble cycle after a redirect, STALL freezes the front end.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/pipe_ctrl.sv
// Purpose: fetch PC generation plus flush/stall control for a 3-stage front end.
// Latency: flush/stall are combinational same cycle; pc_o, misalign_o, jump_cnt_o update on the next edge.
// Backpressure: hold_flag_i | ext_hold_i freezes pc_o and raises stall_o; an accepted jump overrides a hold.
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   jump_en_i/jump_addr_i - redirect request and target from execute
//   hold_flag_i, ext_hold_i - hold requests from execute and memory/bus
//   pc_o                 - registered fetch address
//   if_flush_o/id_flush_o - squash if_id / id_ex this cycle
//   stall_o              - freeze pc, if_id, id_ex this cycle
//   misalign_o           - registered one-cycle pulse on a misaligned jump
//   jump_cnt_o           - wrapping count of accepted jumps
//
// Build option: define JUMP_ALIGN_CHK_EN to redirect misaligned jump targets
// to TRAP_PC and pulse misalign_o; otherwise targets load unchanged.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        ext_hold_i,
    output logic [31:0] pc_o,
    output logic        if_flush_o,
    output logic        id_flush_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] jump_cnt_o
);

    state_t      state_q;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] jump_tgt;
    logic        misalign_nxt;
    logic        jump_acc;
    logic        flush;
    logic        hold;

    assign hold = hold_flag_i | ext_hold_i;

`ifdef JUMP_ALIGN_CHK_EN
    assign misalign_nxt = (jump_addr_i[1:0] != 2'b00);
    assign jump_tgt     = misalign_nxt ? TRAP_PC : jump_addr_i;
`else
    logic unused_trap_pc;
    assign unused_trap_pc = ^TRAP_PC;
    assign misalign_nxt   = 1'b0;
    assign jump_tgt       = jump_addr_i;
`endif

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q_plus4();
        jump_acc  = 1'b0;
        flush     = 1'b0;
        stall_o   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (jump_en_i) begin
                    jump_acc = 1'b1;
                end else if (hold) begin
                    stall_o   = 1'b1;
                    pc_nxt    = pc_o;
                    state_nxt = ST_STALL;
                end
            end
            // The execute stage holds a squashed bubble here, so any jump
            // request it presents is not real and is ignored.
            ST_FLUSH: begin
                state_nxt = hold ? ST_STALL : ST_RUN;
            end
            ST_STALL: begin
                if (jump_en_i) begin
                    jump_acc = 1'b1;
                end else if (hold) begin
                    stall_o = 1'b1;
                    pc_nxt  = pc_o;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if (jump_acc) begin
            flush     = 1'b1;
            pc_nxt    = jump_tgt;
            state_nxt = ST_FLUSH;
        end

        // Reset squashes both pipeline registers and never stalls.
        if (rst) begin
            flush   = 1'b1;
            stall_o = 1'b0;
        end
    end

    assign if_flush_o = flush;
    assign id_flush_o = flush;

    function automatic logic [31:0] pc_q_plus4();
        return pc_o + PC_STEP;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_o       <= RESET_PC;
            misalign_o <= 1'b0;
            jump_cnt_o <= 32'd0;
        end else begin
            state_q    <= state_nxt;
            pc_o       <= pc_nxt;
            misalign_o <= jump_acc & misalign_nxt;
            if (jump_acc) begin
                jump_cnt_o <= jump_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: directed self-checking bench for pipe_ctrl with a queue-based scoreboard.
// Latency: each vector describes the outputs expected in the cycle its inputs are applied.
// Backpressure: n/a.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        ext_hold_i;
    logic [31:0] pc_o;
    logic        if_flush_o;
    logic        id_flush_o;
    logic        stall_o;
    logic        misalign_o;
    logic [31:0] jump_cnt_o;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        flush;
        logic        stall;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

`ifdef JUMP_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .hold_flag_i (hold_flag_i),
        .ext_hold_i  (ext_hold_i),
        .pc_o        (pc_o),
        .if_flush_o  (if_flush_o),
        .id_flush_o  (id_flush_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .jump_cnt_o  (jump_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the rising edge and queue the
    // outputs expected while those inputs are held.
    task automatic step(input string nm, input logic r, input logic je,
                        input logic [31:0] ja, input logic hf, input logic eh,
                        input logic [31:0] e_pc, input logic e_fl, input logic e_st,
                        input logic e_mis, input logic [31:0] e_cnt);
        exp_t e;
        #1;
        rst         = r;
        jump_en_i   = je;
        jump_addr_i = ja;
        hold_flag_i = hf;
        ext_hold_i  = eh;
        e.name  = nm;
        e.pc    = e_pc;
        e.flush = e_fl;
        e.stall = e_st;
        e.mis   = e_mis;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            chk({e.name, " pc"},       pc_o,       e.pc);
            chk({e.name, " if_flush"}, {31'd0, if_flush_o}, {31'd0, e.flush});
            chk({e.name, " id_flush"}, {31'd0, id_flush_o}, {31'd0, e.flush});
            chk({e.name, " stall"},    {31'd0, stall_o},    {31'd0, e.stall});
            chk({e.name, " misalign"}, {31'd0, misalign_o}, {31'd0, e.mis});
            chk({e.name, " jump_cnt"}, jump_cnt_o, e.cnt);
        end
    end

    initial begin
        logic [31:0] mis_pc;
        int          wait_cyc;
        mis_pc      = ALIGN_CHK ? 32'h100 : 32'h102;
        rst         = 1'b1;
        jump_en_i   = 1'b0;
        jump_addr_i = 32'd0;
        hold_flag_i = 1'b0;
        ext_hold_i  = 1'b0;
        @(posedge clk);

        //    name         rst je addr          hf eh   pc             fl st mis cnt
        step("reset",      1, 0, 32'h0,        0, 0,  32'h0,         1, 0, 0,  0);
        step("seq0",       0, 0, 32'h0,        0, 0,  32'h0,         0, 0, 0,  0);
        step("seq4",       0, 0, 32'h0,        0, 0,  32'h4,         0, 0, 0,  0);
        step("seq8",       0, 0, 32'h0,        0, 0,  32'h8,         0, 0, 0,  0);
        step("seqC",       0, 0, 32'h0,        0, 0,  32'hC,         0, 0, 0,  0);
        step("jmp80",      0, 1, 32'h80,       0, 0,  32'h10,        1, 0, 0,  0);
        step("flush_ign",  0, 1, 32'h300,      0, 0,  32'h80,        0, 0, 0,  1);
        step("post84",     0, 0, 32'h0,        0, 0,  32'h84,        0, 0, 0,  1);
        step("jmp1C",      0, 1, 32'h1C,       0, 0,  32'h88,        1, 0, 0,  1);
        step("flush1C",    0, 0, 32'h0,        0, 0,  32'h1C,        0, 0, 0,  2);
        step("ehold1",     0, 0, 32'h0,        0, 1,  32'h20,        0, 1, 0,  2);
        step("ehold2",     0, 0, 32'h0,        0, 1,  32'h20,        0, 1, 0,  2);
        step("ehold3",     0, 0, 32'h0,        0, 1,  32'h20,        0, 1, 0,  2);
        step("unhold",     0, 0, 32'h0,        0, 0,  32'h20,        0, 0, 0,  2);
        step("after24",    0, 0, 32'h0,        0, 0,  32'h24,        0, 0, 0,  2);
        step("hflag",      0, 0, 32'h0,        1, 0,  32'h28,        0, 1, 0,  2);
        step("hold_jmp",   0, 1, 32'h200,      1, 0,  32'h28,        1, 0, 0,  2);
        step("flush200",   0, 0, 32'h0,        1, 0,  32'h200,       0, 0, 0,  3);
        step("stall_rel",  0, 0, 32'h0,        0, 0,  32'h204,       0, 0, 0,  3);
        step("jmp102",     0, 1, 32'h102,      0, 0,  32'h208,       1, 0, 0,  3);
        step("mis_tgt",    0, 0, 32'h0,        0, 0,  mis_pc,        0, 0, ALIGN_CHK, 4);
        step("jmp3C",      0, 1, 32'h3C,       0, 0,  mis_pc + 32'd4, 1, 0, 0, 4);
        step("flush_hold", 0, 0, 32'h0,        0, 1,  32'h3C,        0, 0, 0,  5);
        step("stall40",    0, 0, 32'h0,        0, 1,  32'h40,        0, 1, 0,  5);
        step("rst_stall",  1, 1, 32'h500,      0, 1,  32'h40,        1, 0, 0,  5);
        step("post_rst",   0, 0, 32'h0,        0, 0,  32'h0,         0, 0, 0,  0);
        step("jmp_top",    0, 1, 32'hFFFF_FFF8, 0, 0, 32'h4,         1, 0, 0,  0);
        step("top_f8",     0, 0, 32'h0,        0, 0,  32'hFFFF_FFF8, 0, 0, 0,  1);
        step("top_fc",     0, 0, 32'h0,        0, 0,  32'hFFFF_FFFC, 0, 0, 0,  1);
        step("wrap0",      0, 0, 32'h0,        0, 0,  32'h0,         0, 0, 0,  1);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
